// File: rtl/arp_eth_rx_if.sv
// Ethernet header + byte-wide payload stream into the ARP parser, and the parsed ARP frame out of it.
interface arp_eth_rx_if;
  logic        s_eth_hdr_valid;
  logic        s_eth_hdr_ready;
  logic [47:0] s_eth_dest_mac;
  logic [47:0] s_eth_src_mac;
  logic [15:0] s_eth_type;
  logic [7:0]  s_eth_payload_axis_tdata;
  logic        s_eth_payload_axis_tkeep;
  logic        s_eth_payload_axis_tvalid;
  logic        s_eth_payload_axis_tready;
  logic        s_eth_payload_axis_tlast;
  logic        s_eth_payload_axis_tuser;

  logic        m_frame_valid;
  logic        m_frame_ready;
  logic [47:0] m_eth_dest_mac;
  logic [47:0] m_eth_src_mac;
  logic [15:0] m_eth_type;
  logic [15:0] m_arp_htype;
  logic [15:0] m_arp_ptype;
  logic [7:0]  m_arp_hlen;
  logic [7:0]  m_arp_plen;
  logic [15:0] m_arp_oper;
  logic [47:0] m_arp_sha;
  logic [31:0] m_arp_spa;
  logic [47:0] m_arp_tha;
  logic [31:0] m_arp_tpa;

  // Parser-side view.
  modport slave (
    input  s_eth_hdr_valid, s_eth_dest_mac, s_eth_src_mac, s_eth_type,
    input  s_eth_payload_axis_tdata, s_eth_payload_axis_tkeep, s_eth_payload_axis_tvalid,
    input  s_eth_payload_axis_tlast, s_eth_payload_axis_tuser, m_frame_ready,
    output s_eth_hdr_ready, s_eth_payload_axis_tready, m_frame_valid,
    output m_eth_dest_mac, m_eth_src_mac, m_eth_type,
    output m_arp_htype, m_arp_ptype, m_arp_hlen, m_arp_plen, m_arp_oper,
    output m_arp_sha, m_arp_spa, m_arp_tha, m_arp_tpa
  );

  // Environment-side view (Ethernet RX source and ARP engine sink).
  modport master (
    output s_eth_hdr_valid, s_eth_dest_mac, s_eth_src_mac, s_eth_type,
    output s_eth_payload_axis_tdata, s_eth_payload_axis_tkeep, s_eth_payload_axis_tvalid,
    output s_eth_payload_axis_tlast, s_eth_payload_axis_tuser, m_frame_ready,
    input  s_eth_hdr_ready, s_eth_payload_axis_tready, m_frame_valid,
    input  m_eth_dest_mac, m_eth_src_mac, m_eth_type,
    input  m_arp_htype, m_arp_ptype, m_arp_hlen, m_arp_plen, m_arp_oper,
    input  m_arp_sha, m_arp_spa, m_arp_tha, m_arp_tpa
  );
endinterface

// File: rtl/arp_eth_rx.sv
// ARP receive parser: deserialises the 28-byte ARP body, drops padding/malformed frames.
// Frame valid one cycle after the tlast beat; holds one frame, stalls header and payload until consumed.
module arp_eth_rx #(
  parameter bit CHECK_FORMAT   = 1'b1,
  parameter bit CHECK_ETH_TYPE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  arp_eth_rx_if.slave  bus,
  output logic         busy,
  output logic         error_early_termination,
  output logic         error_bad_frame,
  output logic         error_invalid_format
);

  typedef enum logic [1:0] {IDLE, READ, DROP, OUTPUT} state_t;

  state_t     state;
  logic [4:0] cnt;
  logic       good;
  logic       beat;
  logic       fmt_ok;
  logic       full_len_end;
  logic       unused_tkeep;

  assign unused_tkeep = bus.s_eth_payload_axis_tkeep;
  assign busy         = (state != IDLE);
  assign beat         = bus.s_eth_payload_axis_tvalid && bus.s_eth_payload_axis_tready;
  assign fmt_ok       = !CHECK_FORMAT ||
                        (bus.m_arp_htype == 16'h0001 && bus.m_arp_ptype == 16'h0800 &&
                         bus.m_arp_hlen == 8'd6 && bus.m_arp_plen == 8'd4);
  // tlast of a frame whose 28 ARP bytes all arrived, either exactly or followed by padding.
  assign full_len_end = beat && bus.s_eth_payload_axis_tlast &&
                        ((state == READ && cnt == 5'd27) || (state == DROP && good));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state                         <= IDLE;
      cnt                           <= 5'd0;
      good                          <= 1'b0;
      bus.s_eth_hdr_ready           <= 1'b0;
      bus.s_eth_payload_axis_tready <= 1'b0;
      bus.m_frame_valid             <= 1'b0;
      error_early_termination       <= 1'b0;
      error_bad_frame               <= 1'b0;
      error_invalid_format          <= 1'b0;
      bus.m_eth_dest_mac            <= '0;
      bus.m_eth_src_mac             <= '0;
      bus.m_eth_type                <= '0;
      bus.m_arp_htype               <= '0;
      bus.m_arp_ptype               <= '0;
      bus.m_arp_hlen                <= '0;
      bus.m_arp_plen                <= '0;
      bus.m_arp_oper                <= '0;
      bus.m_arp_sha                 <= '0;
      bus.m_arp_spa                 <= '0;
      bus.m_arp_tha                 <= '0;
      bus.m_arp_tpa                 <= '0;
    end else begin
      error_early_termination <= 1'b0;
      error_bad_frame         <= 1'b0;
      error_invalid_format    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.s_eth_hdr_ready && bus.s_eth_hdr_valid) begin
            bus.m_eth_dest_mac            <= bus.s_eth_dest_mac;
            bus.m_eth_src_mac             <= bus.s_eth_src_mac;
            bus.m_eth_type                <= bus.s_eth_type;
            cnt                           <= 5'd0;
            good                          <= 1'b0;
            bus.s_eth_hdr_ready           <= 1'b0;
            bus.s_eth_payload_axis_tready <= 1'b1;
            state <= (CHECK_ETH_TYPE && bus.s_eth_type != 16'h0806) ? DROP : READ;
          end else begin
            bus.s_eth_hdr_ready <= 1'b1;
          end
        end
        READ, DROP: begin
          if (beat) begin
            if (state == READ) begin
              case (cnt) inside
                5'd0:           bus.m_arp_htype[15:8] <= bus.s_eth_payload_axis_tdata;
                5'd1:           bus.m_arp_htype[7:0]  <= bus.s_eth_payload_axis_tdata;
                5'd2:           bus.m_arp_ptype[15:8] <= bus.s_eth_payload_axis_tdata;
                5'd3:           bus.m_arp_ptype[7:0]  <= bus.s_eth_payload_axis_tdata;
                5'd4:           bus.m_arp_hlen        <= bus.s_eth_payload_axis_tdata;
                5'd5:           bus.m_arp_plen        <= bus.s_eth_payload_axis_tdata;
                5'd6:           bus.m_arp_oper[15:8]  <= bus.s_eth_payload_axis_tdata;
                5'd7:           bus.m_arp_oper[7:0]   <= bus.s_eth_payload_axis_tdata;
                [5'd8:5'd13]:   bus.m_arp_sha[8*(13-int'(cnt)) +: 8] <= bus.s_eth_payload_axis_tdata;
                [5'd14:5'd17]:  bus.m_arp_spa[8*(17-int'(cnt)) +: 8] <= bus.s_eth_payload_axis_tdata;
                [5'd18:5'd23]:  bus.m_arp_tha[8*(23-int'(cnt)) +: 8] <= bus.s_eth_payload_axis_tdata;
                [5'd24:5'd27]:  bus.m_arp_tpa[8*(27-int'(cnt)) +: 8] <= bus.s_eth_payload_axis_tdata;
                default: ;
              endcase
              if (cnt == 5'd27) begin
                good  <= 1'b1;
                state <= DROP;
              end else begin
                cnt <= cnt + 5'd1;
              end
            end
            // Any tlast ends the frame; this overrides the READ->DROP step above.
            if (bus.s_eth_payload_axis_tlast) begin
              bus.s_eth_payload_axis_tready <= 1'b0;
              bus.s_eth_hdr_ready           <= 1'b1;
              state                         <= IDLE;
              if (full_len_end) begin
                if (bus.s_eth_payload_axis_tuser) begin
                  error_bad_frame <= 1'b1;
                end else if (!fmt_ok) begin
                  error_invalid_format <= 1'b1;
                end else begin
                  bus.s_eth_hdr_ready <= 1'b0;
                  bus.m_frame_valid   <= 1'b1;
                  state               <= OUTPUT;
                end
              end else if (state == READ) begin
                error_early_termination <= 1'b1;
              end
            end
          end
        end
        OUTPUT: begin
          if (bus.m_frame_ready) begin
            bus.m_frame_valid   <= 1'b0;
            bus.s_eth_hdr_ready <= 1'b1;
            state               <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arp_eth_rx.sv
// Directed bench for arp_eth_rx: drives on the falling edge, checks on the falling edge.
module tb_arp_eth_rx;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy, e_early, e_bad, e_fmt;
  int   checks = 0;
  int   failures = 0;

  localparam logic [47:0]  DST = 48'hFFFFFFFFFFFF;
  localparam logic [47:0]  SRC = 48'h5A5152535455;
  localparam logic [223:0] BODY = {16'h0001, 16'h0800, 8'd6, 8'd4, 16'h0001,
                                   48'h5A5152535455, 32'hC0A80164, 48'h0, 32'hC0A80165};
  localparam logic [223:0] BODY2 = {16'h0001, 16'h0800, 8'd6, 8'd4, 16'h0002,
                                    48'h001122334455, 32'h0A000001, 48'h5A5152535455, 32'h0A000002};
  localparam logic [223:0] BODY_FMT = {16'h0006, 16'h0800, 8'd6, 8'd4, 16'h0001,
                                       48'h5A5152535455, 32'hC0A80164, 48'h0, 32'hC0A80165};

  always #5 clk = ~clk;

  arp_eth_rx_if bus();

  arp_eth_rx #(.CHECK_FORMAT(1'b1), .CHECK_ETH_TYPE(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy),
    .error_early_termination(e_early), .error_bad_frame(e_bad), .error_invalid_format(e_fmt)
  );

  logic [7:0]   fb [0:63];
  logic [223:0] got_body;
  logic [111:0] got_eth;
  assign got_body = {bus.m_arp_htype, bus.m_arp_ptype, bus.m_arp_hlen, bus.m_arp_plen, bus.m_arp_oper,
                     bus.m_arp_sha, bus.m_arp_spa, bus.m_arp_tha, bus.m_arp_tpa};
  assign got_eth  = {bus.m_eth_dest_mac, bus.m_eth_src_mac, bus.m_eth_type};

  task automatic build(input logic [223:0] body);
    for (int i = 0; i < 28; i++) fb[i] = body[223-8*i -: 8];
    for (int i = 28; i < 64; i++) fb[i] = 8'hEE;
  endtask

  task automatic send_hdr(input logic [15:0] etype);
    int n;
    n = 0;
    bus.s_eth_dest_mac = DST; bus.s_eth_src_mac = SRC; bus.s_eth_type = etype;
    bus.s_eth_hdr_valid = 1'b1;
    while (bus.s_eth_hdr_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n == 50) begin
      checks++; failures++;
      $display("FAIL hdr_timeout: hdr_ready never rose within %0d cycles", n);
    end else begin
      @(posedge clk); @(negedge clk);
    end
    bus.s_eth_hdr_valid = 1'b0;
  endtask

  task automatic send_byte(input int idx, input logic last, input logic user);
    int n;
    n = 0;
    bus.s_eth_payload_axis_tdata = fb[idx];
    bus.s_eth_payload_axis_tlast = last;
    bus.s_eth_payload_axis_tuser = user;
    bus.s_eth_payload_axis_tvalid = 1'b1;
    while (bus.s_eth_payload_axis_tready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n == 50) begin
      checks++; failures++;
      $display("FAIL beat_timeout: byte %0d not accepted within %0d cycles", idx, n);
    end else begin
      @(posedge clk); @(negedge clk);
    end
    if (last) begin
      bus.s_eth_payload_axis_tvalid = 1'b0;
      bus.s_eth_payload_axis_tlast = 1'b0;
      bus.s_eth_payload_axis_tuser = 1'b0;
    end
  endtask

  task automatic accept_frame();
    bus.m_frame_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.m_frame_ready = 1'b0;
    checks++; if (bus.m_frame_valid !== 1'b0) begin failures++; $display("FAIL accept_valid_drop: got %b want 0", bus.m_frame_valid); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if ({bus.s_eth_hdr_ready, bus.s_eth_payload_axis_tready, bus.m_frame_valid, busy} !== 4'b0) begin failures++; $display("FAIL reset_ctrl: got %b want 0000", {bus.s_eth_hdr_ready, bus.s_eth_payload_axis_tready, bus.m_frame_valid, busy}); end
    checks++; if ({e_early, e_bad, e_fmt} !== 3'b0) begin failures++; $display("FAIL reset_err: got %b want 000", {e_early, e_bad, e_fmt}); end
    checks++; if ({got_body, got_eth} !== 336'b0) begin failures++; $display("FAIL reset_fields: got %h want 0", {got_body, got_eth}); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.s_eth_hdr_ready !== 1'b1) begin failures++; $display("FAIL reset_release_hdr_ready: got %b want 1", bus.s_eth_hdr_ready); end
  endtask

  task automatic test_basic();
    build(BODY);
    send_hdr(16'h0806);
    for (int i = 0; i < 27; i++) begin
      send_byte(i, 1'b0, 1'b0);
      if (i == 11) begin
        bus.s_eth_payload_axis_tvalid = 1'b0;
        repeat (3) @(negedge clk);
      end
    end
    checks++; if (bus.m_frame_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_early: got %b want 0", bus.m_frame_valid); end
    send_byte(27, 1'b1, 1'b0);
    checks++; if (bus.m_frame_valid !== 1'b1) begin failures++; $display("FAIL basic_valid: got %b want 1", bus.m_frame_valid); end
    checks++; if (got_body !== BODY) begin failures++; $display("FAIL basic_body: got %h want %h", got_body, BODY); end
    checks++; if (got_eth !== {DST, SRC, 16'h0806}) begin failures++; $display("FAIL basic_eth: got %h want %h", got_eth, {DST, SRC, 16'h0806}); end
    checks++; if ({e_early, e_bad, e_fmt} !== 3'b0) begin failures++; $display("FAIL basic_err: got %b want 000", {e_early, e_bad, e_fmt}); end
    accept_frame();
  endtask

  task automatic test_padding();
    build(BODY);
    send_hdr(16'h0806);
    for (int i = 0; i < 45; i++) begin
      send_byte(i, 1'b0, 1'b0);
      if (i == 27) begin
        checks++; if ({bus.m_frame_valid, busy} !== 2'b01) begin failures++; $display("FAIL pad_mid: valid,busy got %b want 01", {bus.m_frame_valid, busy}); end
      end
    end
    send_byte(45, 1'b1, 1'b0);
    checks++; if (bus.m_frame_valid !== 1'b1) begin failures++; $display("FAIL pad_valid: got %b want 1", bus.m_frame_valid); end
    checks++; if (got_body !== BODY) begin failures++; $display("FAIL pad_body: got %h want %h", got_body, BODY); end
    checks++; if ({e_early, e_bad, e_fmt} !== 3'b0) begin failures++; $display("FAIL pad_err: got %b want 000", {e_early, e_bad, e_fmt}); end
    accept_frame();
  endtask

  task automatic test_early();
    build(BODY);
    send_hdr(16'h0806);
    for (int i = 0; i < 10; i++) send_byte(i, 1'b0, 1'b0);
    send_byte(10, 1'b1, 1'b0);
    checks++; if ({e_early, e_bad, e_fmt, bus.m_frame_valid} !== 4'b1000) begin failures++; $display("FAIL early_pulse: early,bad,fmt,valid got %b want 1000", {e_early, e_bad, e_fmt, bus.m_frame_valid}); end
    @(negedge clk);
    checks++; if ({e_early, bus.m_frame_valid} !== 2'b00) begin failures++; $display("FAIL early_one_cycle: early,valid got %b want 00", {e_early, bus.m_frame_valid}); end
    build(BODY2);
    send_hdr(16'h0806);
    for (int i = 0; i < 28; i++) send_byte(i, i == 27, 1'b0);
    checks++; if (got_body !== BODY2 || bus.m_frame_valid !== 1'b1) begin failures++; $display("FAIL early_next_frame: valid %b body %h want 1 %h", bus.m_frame_valid, got_body, BODY2); end
    accept_frame();
  endtask

  task automatic test_bad_frame();
    build(BODY);
    send_hdr(16'h0806);
    for (int i = 0; i < 28; i++) send_byte(i, i == 27, i == 27);
    checks++; if ({e_early, e_bad, e_fmt, bus.m_frame_valid} !== 4'b0100) begin failures++; $display("FAIL bad_exact: early,bad,fmt,valid got %b want 0100", {e_early, e_bad, e_fmt, bus.m_frame_valid}); end
    send_hdr(16'h0806);
    for (int i = 0; i < 46; i++) send_byte(i, i == 45, i == 45);
    checks++; if ({e_early, e_bad, e_fmt, bus.m_frame_valid} !== 4'b0100) begin failures++; $display("FAIL bad_padded: early,bad,fmt,valid got %b want 0100", {e_early, e_bad, e_fmt, bus.m_frame_valid}); end
  endtask

  task automatic test_format();
    build(BODY_FMT);
    send_hdr(16'h0806);
    for (int i = 0; i < 28; i++) send_byte(i, i == 27, 1'b0);
    checks++; if ({e_early, e_bad, e_fmt, bus.m_frame_valid} !== 4'b0010) begin failures++; $display("FAIL fmt_pulse: early,bad,fmt,valid got %b want 0010", {e_early, e_bad, e_fmt, bus.m_frame_valid}); end
    @(negedge clk);
    checks++; if ({e_fmt, busy} !== 2'b00) begin failures++; $display("FAIL fmt_after: fmt,busy got %b want 00", {e_fmt, busy}); end
  endtask

  task automatic test_back_to_back();
    build(BODY);
    send_hdr(16'h0806);
    for (int i = 0; i < 28; i++) send_byte(i, i == 27, 1'b0);
    build(BODY2);
    bus.s_eth_type = 16'h0806;
    bus.s_eth_hdr_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++; if ({bus.m_frame_valid, bus.s_eth_hdr_ready} !== 2'b10 || got_body !== BODY) begin failures++; $display("FAIL bp_hold%0d: valid,hdr_ready %b body %h want 10 %h", k, {bus.m_frame_valid, bus.s_eth_hdr_ready}, got_body, BODY); end
      @(negedge clk);
    end
    bus.m_frame_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.m_frame_ready = 1'b0;
    checks++; if ({bus.m_frame_valid, busy, bus.s_eth_hdr_ready} !== 3'b001) begin failures++; $display("FAIL bp_handshake: valid,busy,hdr_ready got %b want 001", {bus.m_frame_valid, busy, bus.s_eth_hdr_ready}); end
    @(posedge clk); @(negedge clk);
    bus.s_eth_hdr_valid = 1'b0;
    checks++; if ({busy, bus.s_eth_payload_axis_tready} !== 2'b11) begin failures++; $display("FAIL bp_second_hdr: busy,tready got %b want 11", {busy, bus.s_eth_payload_axis_tready}); end
    for (int i = 0; i < 28; i++) send_byte(i, i == 27, 1'b0);
    checks++; if (got_body !== BODY2 || bus.m_frame_valid !== 1'b1) begin failures++; $display("FAIL bp_second_body: valid %b body %h want 1 %h", bus.m_frame_valid, got_body, BODY2); end
    accept_frame();
  endtask

  task automatic test_non_arp();
    logic seen;
    seen = 1'b0;
    build(BODY);
    send_hdr(16'h0800);
    for (int i = 0; i < 30; i++) begin
      send_byte(i, i == 29, 1'b0);
      if (e_early || e_bad || e_fmt || bus.m_frame_valid) seen = 1'b1;
    end
    checks++; if ({seen, busy} !== 2'b00) begin failures++; $display("FAIL non_arp: any_out_or_err,busy got %b want 00", {seen, busy}); end
  endtask

  task automatic test_reset_mid();
    build(BODY2);
    send_hdr(16'h0806);
    for (int i = 0; i < 15; i++) send_byte(i, 1'b0, 1'b0);
    bus.s_eth_payload_axis_tdata = fb[15];
    bus.s_eth_payload_axis_tvalid = 1'b1;
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    bus.s_eth_payload_axis_tvalid = 1'b0;
    checks++; if ({bus.s_eth_hdr_ready, bus.s_eth_payload_axis_tready, bus.m_frame_valid, busy, e_early, e_bad, e_fmt} !== 7'b0) begin failures++; $display("FAIL rstmid_ctrl: got %b want 0000000", {bus.s_eth_hdr_ready, bus.s_eth_payload_axis_tready, bus.m_frame_valid, busy, e_early, e_bad, e_fmt}); end
    checks++; if ({got_body, got_eth} !== 336'b0) begin failures++; $display("FAIL rstmid_fields: got %h want 0", {got_body, got_eth}); end
    rst = 1'b1;
    @(negedge clk);
    build(BODY);
    send_hdr(16'h0806);
    for (int i = 0; i < 28; i++) send_byte(i, i == 27, 1'b0);
    checks++; if (got_body !== BODY || bus.m_frame_valid !== 1'b1) begin failures++; $display("FAIL rstmid_clean: valid %b body %h want 1 %h", bus.m_frame_valid, got_body, BODY); end
    accept_frame();
  endtask

  initial begin
    bus.s_eth_hdr_valid = 1'b0;
    bus.s_eth_dest_mac = '0;
    bus.s_eth_src_mac = '0;
    bus.s_eth_type = '0;
    bus.s_eth_payload_axis_tdata = '0;
    bus.s_eth_payload_axis_tkeep = 1'b1;
    bus.s_eth_payload_axis_tvalid = 1'b0;
    bus.s_eth_payload_axis_tlast = 1'b0;
    bus.s_eth_payload_axis_tuser = 1'b0;
    bus.m_frame_ready = 1'b0;
    test_reset();
    test_basic();
    test_padding();
    test_early();
    test_bad_frame();
    test_format();
    test_back_to_back();
    test_non_arp();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/arp_eth_rx.md
Name: arp_eth_rx

Overview:
- Receive-side ARP frame parser, directly upstream of the ARP engine.
- Takes the Ethernet header plus an 8-bit AXI-Stream payload from the Ethernet RX path and deserialises the 28-byte ARP body.
- Presents the result as one parallel ARP frame with a valid/ready handshake, which the ARP engine consumes.
- Discards Ethernet padding and drops malformed frames, pulsing an error flag for each drop.

Parameters:
- CHECK_FORMAT, 1, when 1 drop frames unless htype=0x0001, ptype=0x0800, hlen=6 and plen=4.
- CHECK_ETH_TYPE, 1, when 1 accept and discard the payload of any frame with eth_type != 0x0806; no output and no error.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active-low (rst=0 resets)
- s_eth_hdr_valid  in  1  input header valid
- s_eth_hdr_ready  out  1  input header accepted
- s_eth_dest_mac  in  48  destination MAC
- s_eth_src_mac  in  48  source MAC
- s_eth_type  in  16  EtherType
- s_eth_payload_axis_tdata  in  8  payload byte
- s_eth_payload_axis_tkeep  in  1  byte valid; ignored
- s_eth_payload_axis_tvalid  in  1  payload beat valid
- s_eth_payload_axis_tready  out  1  payload beat accepted
- s_eth_payload_axis_tlast  in  1  last payload byte
- s_eth_payload_axis_tuser  in  1  frame error, sampled on the tlast beat
- m_frame_valid  out  1  parsed frame valid
- m_frame_ready  in  1  consumer accepts frame
- m_eth_dest_mac  out  48  latched destination MAC
- m_eth_src_mac  out  48  latched source MAC
- m_eth_type  out  16  latched EtherType
- m_arp_htype  out  16  hardware type
- m_arp_ptype  out  16  protocol type
- m_arp_hlen  out  8  hardware address length
- m_arp_plen  out  8  protocol address length
- m_arp_oper  out  16  operation
- m_arp_sha  out  48  sender hardware address
- m_arp_spa  out  32  sender protocol address
- m_arp_tha  out  48  target hardware address
- m_arp_tpa  out  32  target protocol address
- busy  out  1  state != IDLE
- error_early_termination  out  1  1-cycle pulse: tlast arrived before byte 27
- error_bad_frame  out  1  1-cycle pulse: tuser=1 on the tlast beat
- error_invalid_format  out  1  1-cycle pulse: CHECK_FORMAT violation

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE, byte counter=0.
  - All ready, valid, busy and error outputs = 0; all field outputs = 0.
  - Reset mid-frame abandons the frame with no error pulse; the remaining upstream bytes stall because tready=0.
- States: IDLE, READ, DROP, OUTPUT.
- IDLE:
  - s_eth_hdr_ready=1; s_eth_payload_axis_tready=0.
  - On hdr_valid&ready: latch the MAC and type fields, clear the counter.
  - Go to DROP if CHECK_ETH_TYPE=1 and type != 0x0806 (drop silent); otherwise go to READ.
- READ:
  - tready=1. Each accepted beat writes byte[cnt] into the field at its network-order offset, big-endian:
    - 0-1 htype, 2-3 ptype, 4 hlen, 5 plen, 6-7 oper
    - 8-13 sha, 14-17 spa, 18-23 tha, 24-27 tpa
  - cnt increments 0..27 as a 5-bit counter with no wrap: it saturates at 27.
  - tlast with cnt<27: pulse error_early_termination, go to IDLE.
  - Beat at cnt=27 with tlast:
    - if tuser=1: pulse error_bad_frame, go to IDLE;
    - else if format check fails: pulse error_invalid_format, go to IDLE;
    - else go to OUTPUT.
  - Beat at cnt=27 without tlast: go to DROP with the frame marked good; padding follows.
- DROP:
  - tready=1; consume beats until tlast.
  - On tlast: if the frame was marked good, apply the same tuser and format checks as above, then go to OUTPUT or pulse the matching error; otherwise go to IDLE silently.
- OUTPUT:
  - m_frame_valid=1; s_eth_hdr_ready=0; tready=0.
  - All m_* fields are held stable until m_frame_valid&m_frame_ready; on that handshake go to IDLE.
  - The next header is accepted no earlier than the cycle after the handshake.
- Latency: m_frame_valid rises on the clock edge following acceptance of the tlast beat.
- Error pulses are registered and assert in the same cycle the state leaves READ/DROP.
- Consecutive frames: at most one frame buffered; no overlap.
- tvalid low in READ/DROP: hold state and counter.
- Hold times: the header handshake takes one cycle; tdata is used only on tvalid&tready.

Test Plan:
- Input: header dst FFFFFFFFFFFF, src 5A5152535455, type 0806, then 28 bytes with htype 0001, ptype 0800, 6/4, oper 0001, sha 5A5152535455, spa C0A80164, tha 0, tpa C0A80165, tlast on byte 27. Required: m_frame_valid one cycle after the last beat, every field equal to the input, no error pulses.
- Same frame padded to 46 bytes, tlast on byte 45 -> identical fields; valid rises one cycle after byte 45; padding is not written into any field.
- tlast on byte 10 -> error_early_termination pulses once; m_frame_valid stays 0; the next header is accepted.
- tuser=1 on the tlast beat -> error_bad_frame pulse, no output. htype=0006 with CHECK_FORMAT=1 -> error_invalid_format pulse, no output.
- m_frame_ready held 0 for 5 cycles -> fields stable, s_eth_hdr_ready=0 throughout; the second frame is accepted only after the handshake. Type 0800 frame -> payload consumed, no output, no errors.
- rst=0 at byte 15 -> all outputs 0 next cycle; a subsequent clean frame parses correctly.
